// File: rtl/free_list_pkg.sv
// free_list_pkg: shared core sizing (N_WAY and CDB_BITS macros plus register counts) and a
// modular pointer helper for the rename free list.
`ifndef N_WAY
`define N_WAY 3
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

package free_list_pkg;

    localparam int N_WAY      = `N_WAY;
    localparam int N_PHYS_REG = 64;
    localparam int N_ARCH_REG = 32;
    localparam int CDB_BITS   = `CDB_BITS;

    // Offsets never exceed the depth, so a single conditional subtract is a full modulo.
    function automatic int ptr_wrap(input int base, input int off, input int depth);
        int sum;
        sum = base + off;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

endpackage

// File: rtl/free_list_if.sv
// free_list_if: per-lane allocation and retirement bus between dispatch/ROB and the free list.
// fl_error exists only when FREE_LIST_ERR_EN is defined.
interface free_list_if #(
    parameter int N_WAY      = free_list_pkg::N_WAY,
    parameter int N_PHYS_REG = free_list_pkg::N_PHYS_REG
);
    localparam int TAG_W  = $clog2(N_PHYS_REG);
    localparam int LANE_W = $clog2(N_WAY) + 1;

    logic [N_WAY-1:0]             alloc_req;
    logic [N_WAY-1:0]             retire_valid;
    logic [N_WAY-1:0][TAG_W-1:0]  retire_told;
    logic [N_WAY-1:0][TAG_W-1:0]  free_tag;
    logic [N_WAY-1:0]             alloc_grant;
    logic [LANE_W-1:0]            free_num;
`ifdef FREE_LIST_ERR_EN
    logic                         fl_error;
`endif

    modport master (
        output alloc_req,
        output retire_valid,
        output retire_told,
        input  free_tag,
        input  alloc_grant,
        input  free_num
`ifdef FREE_LIST_ERR_EN
        , input fl_error
`endif
    );

    modport slave (
        input  alloc_req,
        input  retire_valid,
        input  retire_told,
        output free_tag,
        output alloc_grant,
        output free_num
`ifdef FREE_LIST_ERR_EN
        , output fl_error
`endif
    );

endinterface

// File: rtl/free_list_lane_prefix_count.sv
// lane_prefix_count: exclusive per-lane population count of a bit vector, plus the total.
module lane_prefix_count #(
    parameter int WIDTH = 3,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0]            bits,
    output logic [WIDTH-1:0][CNT_W-1:0] prefix,
    output logic [CNT_W-1:0]            total
);

    always_comb begin
        total  = '0;
        prefix = '0;
        for (int i = 0; i < WIDTH; i++) begin
            prefix[i] = total;
            total     = total + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical tags with N_WAY-wide in-order allocation and retire append.
// Define FREE_LIST_ERR_EN to add the sticky fl_error output (overflow or out-of-range retire).
module free_list
    import free_list_pkg::ptr_wrap;
#(
    parameter int N_WAY      = free_list_pkg::N_WAY,
    parameter int N_PHYS_REG = free_list_pkg::N_PHYS_REG,
    parameter int N_ARCH_REG = free_list_pkg::N_ARCH_REG
) (
    input logic       clock,
    input logic       reset,
    free_list_if.slave fl
);

    localparam int D      = N_PHYS_REG - N_ARCH_REG;
    localparam int TAG_W  = $clog2(N_PHYS_REG);
    localparam int PTR_W  = (D > 1) ? $clog2(D) : 1;
    localparam int CNT_W  = $clog2(D) + 1;
    localparam int LANE_W = $clog2(N_WAY) + 1;

    logic [TAG_W-1:0]              fifo [D];
    logic [PTR_W-1:0]              head;
    logic [PTR_W-1:0]              tail;
    logic [CNT_W-1:0]              count;

    logic [N_WAY-1:0][LANE_W-1:0]  req_off;
    logic [N_WAY-1:0][LANE_W-1:0]  free_off;
    logic [LANE_W-1:0]             req_total;
    logic [LANE_W-1:0]             free_total;
    logic [N_WAY-1:0]              free_valid;
    logic [N_WAY-1:0]              grant;
    logic [N_WAY-1:0]              write_en;
    logic [N_WAY-1:0][PTR_W-1:0]   write_idx;
    logic [CNT_W-1:0]              n_grant;
    logic [CNT_W-1:0]              n_append;
    logic [CNT_W-1:0]              count_after_grant;

    // x0 is never renamed, so a retiring lane releasing it frees nothing.
    always_comb begin
        free_valid = '0;
        for (int i = 0; i < N_WAY; i++) begin
            free_valid[i] = fl.retire_valid[i] && (fl.retire_told[i] != '0);
        end
    end

    lane_prefix_count #(.WIDTH(N_WAY), .CNT_W(LANE_W)) u_req_prefix (
        .bits   (fl.alloc_req),
        .prefix (req_off),
        .total  (req_total)
    );

    lane_prefix_count #(.WIDTH(N_WAY), .CNT_W(LANE_W)) u_free_prefix (
        .bits   (free_valid),
        .prefix (free_off),
        .total  (free_total)
    );

    // Grants form an in-order prefix limited by the pre-edge count; appends fill only the
    // slots left free after this cycle's grants, dropping any excess.
    always_comb begin
        grant     = '0;
        n_grant   = '0;
        n_append  = '0;
        write_en  = '0;
        write_idx = '0;
        for (int i = 0; i < N_WAY; i++) begin
            grant[i] = fl.alloc_req[i] && (CNT_W'(req_off[i]) < count);
            if (grant[i]) begin
                n_grant = n_grant + CNT_W'(1);
            end
        end
        count_after_grant = count - n_grant;
        for (int i = 0; i < N_WAY; i++) begin
            write_idx[i] = PTR_W'(ptr_wrap(int'(tail), int'(free_off[i]), D));
            write_en[i]  = free_valid[i] && ((int'(count_after_grant) + int'(free_off[i])) < D);
            if (write_en[i]) begin
                n_append = n_append + CNT_W'(1);
            end
        end
    end

    always_comb begin
        fl.alloc_grant = grant;
        fl.free_tag    = '0;
        for (int i = 0; i < N_WAY; i++) begin
            fl.free_tag[i] = fifo[PTR_W'(ptr_wrap(int'(head), int'(req_off[i]), D))];
        end
        if (int'(count) >= N_WAY) begin
            fl.free_num = LANE_W'(N_WAY);
        end else begin
            fl.free_num = LANE_W'(count);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < D; k++) begin
                fifo[k] <= TAG_W'(N_ARCH_REG + k);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(D);
        end else begin
            for (int i = 0; i < N_WAY; i++) begin
                if (write_en[i]) begin
                    fifo[write_idx[i]] <= fl.retire_told[i];
                end
            end
            head  <= PTR_W'(ptr_wrap(int'(head), int'(n_grant), D));
            tail  <= PTR_W'(ptr_wrap(int'(tail), int'(n_append), D));
            count <= count_after_grant + n_append;
        end
    end

`ifdef FREE_LIST_ERR_EN
    logic overflow;
    logic bad_tag;

    always_comb begin
        overflow = 1'b0;
        bad_tag  = 1'b0;
        for (int i = 0; i < N_WAY; i++) begin
            if (free_valid[i] && !write_en[i]) begin
                overflow = 1'b1;
            end
            if (fl.retire_valid[i] && (int'(fl.retire_told[i]) >= N_PHYS_REG)) begin
                bad_tag = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fl.fl_error <= 1'b0;
        end else if (overflow || bad_tag) begin
            fl.fl_error <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: randomized and directed checks of free_list against a queue-based model of free tags.
module tb_free_list;

    localparam int NW = free_list_pkg::N_WAY;
    localparam int NP = free_list_pkg::N_PHYS_REG;
    localparam int NA = free_list_pkg::N_ARCH_REG;
    localparam int D  = NP - NA;
    localparam int TW = $clog2(NP);

    logic clock = 1'b0;
    logic reset = 1'b0;

    free_list_if #(.N_WAY(NW), .N_PHYS_REG(NP)) fl_bus ();

    free_list #(.N_WAY(NW), .N_PHYS_REG(NP), .N_ARCH_REG(NA)) dut (
        .clock (clock),
        .reset (reset),
        .fl    (fl_bus.slave)
    );

    always #5 clock = ~clock;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int model_q[$];
    bit model_err = 1'b0;

    function automatic logic [NW-1:0] model_grant(input logic [NW-1:0] req);
        logic [NW-1:0] g;
        int n;
        g = '0;
        n = 0;
        for (int i = 0; i < NW; i++) begin
            if (req[i]) begin
                n++;
                if (n <= model_q.size()) g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic int model_num();
        return (model_q.size() < NW) ? model_q.size() : NW;
    endfunction

    function automatic int lanes_below(input logic [NW-1:0] req, input int lane);
        int n;
        n = 0;
        for (int j = 0; j < lane; j++) if (req[j]) n++;
        return n;
    endfunction

    task automatic model_reset();
        model_q.delete();
        for (int k = 0; k < D; k++) model_q.push_back(NA + k);
        model_err = 1'b0;
    endtask

    task automatic model_edge();
        logic [NW-1:0] g;
        g = model_grant(fl_bus.alloc_req);
        for (int i = 0; i < NW; i++) if (g[i]) void'(model_q.pop_front());
        for (int i = 0; i < NW; i++) begin
            if (fl_bus.retire_valid[i] && fl_bus.retire_told[i] != '0) begin
                if (model_q.size() < D) model_q.push_back(int'(fl_bus.retire_told[i]));
                else model_err = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic [NW-1:0] req, input logic [NW-1:0] rv,
                                 input logic [NW-1:0][TW-1:0] told);
        fl_bus.alloc_req    = req;
        fl_bus.retire_valid = rv;
        fl_bus.retire_told  = told;
    endtask

    task automatic advance();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus('0, '0, '0);
        #2 reset = 1'b1;
        model_reset();
        #2;
        check_cnt++;
        if (fl_bus.free_num !== 3'(NW)) $display("[TB] FAIL reset_free_num got %0d want %0d", fl_bus.free_num, NW);
        else pass_cnt++;
        check_cnt++;
        if (fl_bus.alloc_grant !== '0) $display("[TB] FAIL reset_grant got %b want 000", fl_bus.alloc_grant);
        else pass_cnt++;
        applyStimulus('1, '0, '0);
        #1;
        for (int i = 0; i < NW; i++) begin
            check_cnt++;
            if (fl_bus.free_tag[i] !== TW'(NA + i))
                $display("[TB] FAIL reset_tag lane%0d got %0d want %0d", i, fl_bus.free_tag[i], NA + i);
            else pass_cnt++;
        end
        applyStimulus('0, '0, '0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_drain();
        for (int c = 0; c < 10; c++) begin
            applyStimulus('1, '0, '0);
            #1;
            check_cnt++;
            if (fl_bus.alloc_grant !== 3'b111) $display("[TB] FAIL drain_grant cyc%0d got %b want 111", c, fl_bus.alloc_grant);
            else pass_cnt++;
            for (int i = 0; i < NW; i++) begin
                check_cnt++;
                if (fl_bus.free_tag[i] !== TW'(NA + 3 * c + i))
                    $display("[TB] FAIL drain_tag cyc%0d lane%0d got %0d want %0d", c, i, fl_bus.free_tag[i], NA + 3 * c + i);
                else pass_cnt++;
            end
            advance();
        end
        #1;
        check_cnt++;
        if (fl_bus.alloc_grant !== 3'b011) $display("[TB] FAIL drain_partial_grant got %b want 011", fl_bus.alloc_grant);
        else pass_cnt++;
        check_cnt++;
        if (fl_bus.free_tag[0] !== TW'(62) || fl_bus.free_tag[1] !== TW'(63))
            $display("[TB] FAIL drain_last_tags got %0d,%0d want 62,63", fl_bus.free_tag[0], fl_bus.free_tag[1]);
        else pass_cnt++;
        advance();
        #1;
        check_cnt++;
        if (fl_bus.free_num !== 3'd0 || fl_bus.alloc_grant !== 3'b000)
            $display("[TB] FAIL empty_state got num=%0d grant=%b want num=0 grant=000", fl_bus.free_num, fl_bus.alloc_grant);
        else pass_cnt++;
    endtask

    task automatic test_refill_latency();
        applyStimulus('0, 3'b111, {TW'(9), TW'(6), TW'(3)});
        #1;
        check_cnt++;
        if (fl_bus.free_num !== 3'd0) $display("[TB] FAIL no_bypass got %0d want 0", fl_bus.free_num);
        else pass_cnt++;
        advance();
        applyStimulus('1, '0, '0);
        #1;
        check_cnt++;
        if (fl_bus.free_num !== 3'd3) $display("[TB] FAIL refill_num got %0d want 3", fl_bus.free_num);
        else pass_cnt++;
        check_cnt++;
        if (fl_bus.free_tag[0] !== TW'(3) || fl_bus.free_tag[1] !== TW'(6) || fl_bus.free_tag[2] !== TW'(9))
            $display("[TB] FAIL refill_tags got %0d,%0d,%0d want 3,6,9",
                     fl_bus.free_tag[0], fl_bus.free_tag[1], fl_bus.free_tag[2]);
        else pass_cnt++;
        applyStimulus(3'b011, '0, '0);
        advance();
    endtask

    task automatic test_simultaneous();
        applyStimulus(3'b111, 3'b111, {TW'(12), TW'(0), TW'(10)});
        #1;
        check_cnt++;
        if (fl_bus.alloc_grant !== 3'b001) $display("[TB] FAIL simul_grant got %b want 001", fl_bus.alloc_grant);
        else pass_cnt++;
        check_cnt++;
        if (fl_bus.free_tag[0] !== TW'(9)) $display("[TB] FAIL simul_tag got %0d want 9", fl_bus.free_tag[0]);
        else pass_cnt++;
        advance();
        applyStimulus(3'b111, '0, '0);
        #1;
        check_cnt++;
        if (fl_bus.free_num !== 3'd2 || fl_bus.alloc_grant !== 3'b011)
            $display("[TB] FAIL simul_count got num=%0d grant=%b want num=2 grant=011", fl_bus.free_num, fl_bus.alloc_grant);
        else pass_cnt++;
        check_cnt++;
        if (fl_bus.free_tag[0] !== TW'(10) || fl_bus.free_tag[1] !== TW'(12))
            $display("[TB] FAIL simul_order got %0d,%0d want 10,12", fl_bus.free_tag[0], fl_bus.free_tag[1]);
        else pass_cnt++;
        advance();
    endtask

    task automatic test_wrap();
        logic [NW-1:0] req;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            applyStimulus('1, '0, '0);
            advance();
        end
        for (int k = 0; k < 40; k++) begin
            req = (k >= 4) ? 3'b001 : 3'b000;
            applyStimulus(req, 3'b001, {TW'(0), TW'(0), TW'(k + 1)});
            #1;
            check_cnt++;
            if (fl_bus.alloc_grant !== model_grant(req))
                $display("[TB] FAIL wrap_grant k%0d got %b want %b", k, fl_bus.alloc_grant, model_grant(req));
            else pass_cnt++;
            if (req[0] && model_q.size() > 0) begin
                check_cnt++;
                if (fl_bus.free_tag[0] !== TW'(model_q[0]))
                    $display("[TB] FAIL wrap_tag k%0d got %0d want %0d", k, fl_bus.free_tag[0], model_q[0]);
                else pass_cnt++;
            end
            advance();
        end
        do_reset();
        applyStimulus('0, 3'b001, {TW'(0), TW'(0), TW'(5)});
        advance();
        applyStimulus('1, '0, '0);
        #1;
        check_cnt++;
        if (fl_bus.free_tag[0] !== TW'(NA) || fl_bus.free_tag[2] !== TW'(NA + 2) || fl_bus.free_num !== 3'd3)
            $display("[TB] FAIL overflow_drop got %0d..%0d num=%0d want %0d..%0d num=3",
                     fl_bus.free_tag[0], fl_bus.free_tag[2], fl_bus.free_num, NA, NA + 2);
        else pass_cnt++;
`ifdef FREE_LIST_ERR_EN
        check_cnt++;
        if (fl_bus.fl_error !== 1'b1) $display("[TB] FAIL err_set got %b want 1", fl_bus.fl_error);
        else pass_cnt++;
        applyStimulus('0, '0, '0);
        advance();
        advance();
        check_cnt++;
        if (fl_bus.fl_error !== 1'b1) $display("[TB] FAIL err_sticky got %b want 1", fl_bus.fl_error);
        else pass_cnt++;
        do_reset();
        check_cnt++;
        if (fl_bus.fl_error !== 1'b0) $display("[TB] FAIL err_clear got %b want 0", fl_bus.fl_error);
        else pass_cnt++;
`endif
        applyStimulus('0, '0, '0);
    endtask

    task automatic test_random();
        logic [NW-1:0] req;
        logic [NW-1:0] rv;
        logic [NW-1:0][TW-1:0] told;
        logic [NW-1:0] g;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            req = NW'($urandom);
            rv  = NW'($urandom) & NW'($urandom);
            for (int i = 0; i < NW; i++) told[i] = ($urandom_range(0, 4) == 0) ? TW'(0) : TW'($urandom_range(1, NP - 1));
            applyStimulus(req, rv, told);
            #1;
            g = model_grant(req);
            check_cnt++;
            if (fl_bus.alloc_grant !== g) $display("[TB] FAIL rand_grant cyc%0d got %b want %b", c, fl_bus.alloc_grant, g);
            else pass_cnt++;
            check_cnt++;
            if (fl_bus.free_num !== 3'(model_num())) $display("[TB] FAIL rand_num cyc%0d got %0d want %0d", c, fl_bus.free_num, model_num());
            else pass_cnt++;
            for (int i = 0; i < NW; i++) begin
                if (g[i]) begin
                    check_cnt++;
                    if (fl_bus.free_tag[i] !== TW'(model_q[lanes_below(req, i)]))
                        $display("[TB] FAIL rand_tag cyc%0d lane%0d got %0d want %0d", c, i,
                                 fl_bus.free_tag[i], model_q[lanes_below(req, i)]);
                    else pass_cnt++;
                end
            end
            advance();
        end
`ifdef FREE_LIST_ERR_EN
        check_cnt++;
        if (fl_bus.fl_error !== model_err) $display("[TB] FAIL rand_err got %b want %b", fl_bus.fl_error, model_err);
        else pass_cnt++;
`endif
        applyStimulus('0, '0, '0);
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            applyStimulus('1, '0, '0);
            advance();
        end
        applyStimulus('1, '0, '0);
        #1;
        check_cnt++;
        if (fl_bus.free_tag[0] !== TW'(59) || fl_bus.free_tag[2] !== TW'(61))
            $display("[TB] FAIL midburst_tags got %0d..%0d want 59..61", fl_bus.free_tag[0], fl_bus.free_tag[2]);
        else pass_cnt++;
        #1 reset = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < NW; i++) begin
            check_cnt++;
            if (fl_bus.free_tag[i] !== TW'(NA + i))
                $display("[TB] FAIL async_reset_tag lane%0d got %0d want %0d", i, fl_bus.free_tag[i], NA + i);
            else pass_cnt++;
        end
        applyStimulus('0, '0, '0);
        #1;
        check_cnt++;
        if (fl_bus.free_num !== 3'(NW) || fl_bus.alloc_grant !== '0)
            $display("[TB] FAIL async_reset_state got num=%0d grant=%b want num=%0d grant=000", fl_bus.free_num, fl_bus.alloc_grant, NW);
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_drain();
        test_refill_latency();
        test_simultaneous();
        test_wrap();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter N_WAY, default `N_WAY (3): superscalar width, one lane per dispatch/retire slot.
REQ-002 SHALL have parameter N_PHYS_REG, default 64: number of physical registers; tag width is `CDB_BITS = clog2(N_PHYS_REG).
REQ-003 SHALL have parameter N_ARCH_REG, default 32: architectural registers; free-list depth is N_PHYS_REG-N_ARCH_REG (32).
REQ-004 Port: clock  in  1  single clock; all state updates on the rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: alloc_req  in  [N_WAY]  per-lane dispatch request for a new physical tag.
REQ-007 Port: retire_valid  in  [N_WAY]  per-lane ROB retirement valid.
REQ-008 Port: retire_told  in  [N_WAY][`CDB_BITS]  old physical tag released by each retiring lane.
REQ-009 Port: free_tag  out  [N_WAY][`CDB_BITS]  tag offered to each lane this cycle.
REQ-010 Port: alloc_grant  out  [N_WAY]  lane request granted; tag consumed at the next edge.
REQ-011 Port: free_num  out  [clog2(N_WAY)+1]  min(count, N_WAY); dispatch-stall input.

Function
REQ-012 SHALL hold free tags in a circular FIFO of depth D=N_PHYS_REG-N_ARCH_REG, with head, tail and count registers (count width clog2(D)+1).
REQ-013 free_tag[i] SHALL equal fifo[head + (number of requesting lanes below i)] mod D, combinationally.
REQ-014 alloc_grant SHALL be an in-order prefix: lane i is granted iff alloc_req[i]=1 and the count of requesting lanes at or below i is <= count; a denied lane denies all higher lanes.
REQ-015 Zero-latency allocation: granted tags leave the FIFO at the next edge; head advances by the number of grants, modulo D.
REQ-016 Retiring lanes with retire_valid=1 and retire_told!=0 SHALL be appended at tail in ascending lane order; a told of 0 (x0) SHALL be dropped.
REQ-017 Freed tags SHALL NOT be offered in the same cycle (one-cycle free-to-reuse latency; no bypass).
REQ-018 On simultaneous allocation and retirement, count_next = count - grants + frees; grants use only the pre-edge count.
REQ-019 Pointers SHALL wrap from D-1 to 0 without losing or reordering tags.
REQ-020 When count=0, all alloc_grant SHALL be 0 and free_num SHALL be 0; free_tag is don't-care.
REQ-021 An append that would exceed D entries SHALL drop the excess tags and leave count at D (illegal by construction).

Reset
REQ-022 reset SHALL immediately (asynchronously) load fifo[k]=N_ARCH_REG+k for k=0..D-1, head=0, tail=0 and count=D, including mid-operation.
REQ-023 After reset: free_num=N_WAY, alloc_grant=0 while alloc_req=0, and free_tag = 32,33,34 for default parameters.

Configuration
REQ-024 Macro FREE_LIST_ERR_EN: when defined, SHALL add output fl_error (1 bit, reset 0), set sticky on overflow (REQ-021) or on a retire of a tag >= N_PHYS_REG; cleared only by reset.
REQ-025 Without FREE_LIST_ERR_EN the fl_error port and its logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-026 N_PHYS_REG, N_ARCH_REG, `N_WAY and `CDB_BITS SHALL live in the shared sys_defs package/header used by rob.
REQ-027 One sub-module, lane_prefix_count, SHALL compute per-lane exclusive prefix counts of a bit vector; it is used for both the grant offsets and the retire-append offsets.

Verification
REQ-028 Reset, no requests -> free_num=3, free_tag={32,33,34}, alloc_grant=0.
REQ-029 alloc_req=3'b111 for 10 cycles -> tags 32..61 granted in order; next cycle count=2, request 111 -> grant=3'b011, tags 62,63; then free_num=0.
REQ-030 Empty list, retire told {3,6,9} valid 111 -> same cycle free_num=0; next cycle free_num=3, free_tag={3,6,9}.
REQ-031 count=1, alloc_req=111, retire told {10,0,12} valid 111 -> grant=3'b001; next cycle count=2, holding {10,12} in order (told 0 dropped).
REQ-032 Allocate all 32 tags, then free 40 tags one per cycle -> head and tail wrap to 0 and reallocation returns the tags in free order; with FREE_LIST_ERR_EN, a retire at count=32 sets fl_error=1 until reset.
REQ-033 Assert reset mid-burst (count=5) -> outputs return within the same cycle to the REQ-028 values.
